frame_assembler: RTL and testbench



---
 rtl/hgcal_frame_pkg.sv | 36 +++
 rtl/frame_fifo.sv | 68 ++++++
 rtl/frame_assembler.sv | 224 ++++++++++++++++++++++
 tb/tb_frame_assembler.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hgcal_frame_pkg.sv
// Shared constants and types for the receive-side frame assembler:
// K-code markers, FSM states and the 38-bit FIFO entry layout.
package hgcal_frame_pkg;

  localparam int unsigned WordW = 32;
  localparam int unsigned KeepW = 4;

  // K27.7 starts a frame, K29.7 ends it; every other K symbol is stray.
  localparam logic [8:0] SofCode = 9'h1FB;
  localparam logic [8:0] EofCode = 9'h1FD;

  typedef enum logic [1:0] {
    StIdle,
    StPayload,
    StDrop
  } state_e;

  typedef struct packed {
    logic [WordW-1:0] data;
    logic [KeepW-1:0] keep;
    logic             last;
    logic             err;
  } fifo_entry_t;

  localparam fifo_entry_t TermEntry = '{data: '0, keep: '0, last: 1'b1, err: 1'b1};

  function automatic logic [KeepW-1:0] keep_mask(input logic [1:0] nbytes);
    case (nbytes)
      2'd0:    keep_mask = 4'b0000;
      2'd1:    keep_mask = 4'b0001;
      2'd2:    keep_mask = 4'b0011;
      default: keep_mask = 4'b0111;
    endcase
  endfunction

endpackage

// File: rtl/frame_fifo.sv
// Synchronous show-ahead FIFO of frame words with registered read-side outputs
// and an occupancy count for the writer's admission check.
module frame_fifo
  import hgcal_frame_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     byteclk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  fifo_entry_t              wr_data,
  input  logic                     rd_ready,
  output fifo_entry_t              rd_data,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam int unsigned OccW  = AddrW + 1;

  fifo_entry_t            mem_q [DEPTH];
  fifo_entry_t            rd_data_q, head_d;
  logic                   rd_valid_q, valid_d;
  logic [AddrW-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
  logic [OccW-1:0]        occ_q, occ_d, occ_after_pop;
  logic                   do_push, do_pop;

  always_comb begin
    do_pop        = rd_valid_q && rd_ready;
    do_push       = wr_en && (occ_q != OccW'(DEPTH));
    occ_after_pop = occ_q - OccW'(do_pop);
    occ_d         = occ_after_pop + OccW'(do_push);
    rptr_d        = rptr_q + AddrW'(do_pop);
    wptr_d        = wptr_q + AddrW'(do_push);
    valid_d       = (occ_d != '0);
    // An empty store after the pop means the incoming word becomes the head.
    head_d        = (occ_after_pop == '0) ? wr_data : mem_q[rptr_d];
  end

  always_ff @(posedge byteclk) begin
    if (do_push) begin
      mem_q[wptr_q] <= wr_data;
    end
  end

  always_ff @(posedge byteclk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      occ_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      occ_q      <= occ_d;
      rd_valid_q <= valid_d;
      if (valid_d) begin
        rd_data_q <= head_d;
      end
    end
  end

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign occupancy = occ_q;

endmodule

// File: rtl/frame_assembler.sv
// Delimits K-coded frames from the 8b/10b decoder and packs payload into 32-bit LE words.
// Optional FRAME_XOR_CHECK_EN: the last payload byte is an XOR checksum of the frame.
module frame_assembler
  import hgcal_frame_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic             byteclk,
  input  logic             rst_n,
  input  logic             link,
  input  logic [8:0]       sym,
  input  logic             sym_vld,
  output logic [WordW-1:0] m_data,
  output logic [KeepW-1:0] m_keep,
  output logic             m_last,
  output logic             m_err,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             in_frame,
  output logic             overflow
);

  localparam int unsigned OccW     = $clog2(DEPTH) + 1;
  localparam logic [8:0]  MaxWords = 9'(MAX_WORDS);

  state_e           state_q, state_d;
  logic [WordW-1:0] lanes_q, lanes_d, hold_q, hold_d;
  logic [1:0]       nbytes_q, nbytes_d;
  logic             hold_vld_q, hold_vld_d;
  logic [8:0]       wcnt_q, wcnt_d;
  logic             err_q, err_d, owed_q, owed_d, ovf_q, ovf_d;
  logic             push, restart, take_byte, xor_bad;
  logic             is_sof, is_eof, is_stray, is_data, room_mid, room_last, pend_empty;
  logic [OccW-1:0]  occupancy;
  fifo_entry_t      push_entry, pend_entry, fifo_out;

  always_comb begin
    is_sof     = sym_vld && (sym == SofCode);
    is_eof     = sym_vld && (sym == EofCode);
    is_stray   = sym_vld && sym[8] && !is_sof && !is_eof;
    is_data    = sym_vld && !sym[8];
    // Non-last pushes leave one slot spare so the frame terminator always fits.
    room_mid   = occupancy < OccW'(DEPTH - 1);
    room_last  = occupancy < OccW'(DEPTH);
    pend_empty = !hold_vld_q && (nbytes_q == 2'd0);
  end

  always_ff @(posedge byteclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    lanes_d    = lanes_q;
    nbytes_d   = nbytes_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    wcnt_d     = wcnt_q;
    err_d      = err_q;
    owed_d     = owed_q;
    ovf_d      = 1'b0;
    push       = 1'b0;
    restart    = 1'b0;
    take_byte  = 1'b0;

    pend_entry.data = hold_vld_q ? hold_q : lanes_q;
    pend_entry.keep = hold_vld_q ? 4'b1111 : keep_mask(nbytes_q);
    pend_entry.last = 1'b1;
    pend_entry.err  = 1'b1;
    push_entry      = pend_entry;

    unique case (state_q)
      StIdle: begin
        if (is_sof && link) begin
          restart = 1'b1;
          state_d = StPayload;
        end
      end

      StPayload: begin
        if (!link || is_sof || is_eof) begin
          push_entry.err = !link || is_sof || pend_empty || err_q || xor_bad;
          if (room_last) begin
            push = 1'b1;
          end else begin
            ovf_d = 1'b1;
          end
          if (!link) begin
            state_d = StIdle;
          end else if (is_sof) begin
            restart = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end else if (is_stray) begin
          err_d = 1'b1;
        end else if (is_data) begin
          if ((wcnt_q == MaxWords) || (hold_vld_q && !room_mid)) begin
            ovf_d   = 1'b1;
            owed_d  = 1'b1;
            state_d = StDrop;
          end else begin
            take_byte = 1'b1;
            if (hold_vld_q) begin
              push            = 1'b1;
              push_entry.data = hold_q;
              push_entry.keep = 4'b1111;
              push_entry.last = 1'b0;
              push_entry.err  = 1'b0;
            end
            lanes_d[{nbytes_q, 3'b000} +: 8] = sym[7:0];
            if (nbytes_q == 2'd3) begin
              hold_d     = lanes_d;
              hold_vld_d = 1'b1;
              lanes_d    = '0;
              nbytes_d   = 2'd0;
              wcnt_d     = wcnt_q + 9'd1;
            end else begin
              hold_vld_d = 1'b0;
              nbytes_d   = nbytes_q + 2'd1;
            end
          end
        end
      end

      StDrop: begin
        if (owed_q) begin
          if (room_last) begin
            push       = 1'b1;
            push_entry = TermEntry;
            owed_d     = 1'b0;
          end
        end else if (!link || is_eof) begin
          state_d = StIdle;
        end else if (is_sof) begin
          restart = 1'b1;
          state_d = StPayload;
        end
      end

      default: state_d = StIdle;
    endcase

    if (restart) begin
      lanes_d    = '0;
      nbytes_d   = 2'd0;
      hold_vld_d = 1'b0;
      wcnt_d     = '0;
      err_d      = 1'b0;
    end
  end

  always_ff @(posedge byteclk or negedge rst_n) begin
    if (!rst_n) begin
      lanes_q    <= '0;
      nbytes_q   <= 2'd0;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      wcnt_q     <= '0;
      err_q      <= 1'b0;
      owed_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      lanes_q    <= lanes_d;
      nbytes_q   <= nbytes_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      wcnt_q     <= wcnt_d;
      err_q      <= err_d;
      owed_q     <= owed_d;
      ovf_q      <= ovf_d;
    end
  end

`ifdef FRAME_XOR_CHECK_EN
  // Running XOR over every payload byte including the checksum; a good frame folds to zero.
  logic [7:0] xor_q;

  always_ff @(posedge byteclk or negedge rst_n) begin
    if (!rst_n) begin
      xor_q <= 8'h00;
    end else if (restart) begin
      xor_q <= 8'h00;
    end else if (take_byte) begin
      xor_q <= xor_q ^ sym[7:0];
    end
  end

  assign xor_bad = (xor_q != 8'h00);
`else
  logic unused_take_byte;
  assign unused_take_byte = take_byte;
  assign xor_bad          = 1'b0;
`endif

  always_comb begin
    in_frame = (state_q == StPayload);
    overflow = ovf_q;
  end

  frame_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .byteclk   (byteclk),
    .rst_n     (rst_n),
    .wr_en     (push),
    .wr_data   (push_entry),
    .rd_ready  (m_ready),
    .rd_data   (fifo_out),
    .rd_valid  (m_valid),
    .occupancy (occupancy)
  );

  assign m_data = fifo_out.data;
  assign m_keep = fifo_out.keep;
  assign m_last = fifo_out.last;
  assign m_err  = fifo_out.err;

endmodule

// File: tb/tb_frame_assembler.sv
// Bench for frame_assembler: directed cases plus randomized frames scored against
// a byte-list reference model of the frame packing rules.
module tb_frame_assembler;

  localparam logic [8:0] SOF    = 9'h1FB;
  localparam logic [8:0] EOF    = 9'h1FD;
  localparam logic [8:0] KSTRAY = 9'h1BC;

  typedef logic [7:0] bq_t [$];

  logic        byteclk = 1'b0;
  logic        rst_n;
  logic        link;
  logic [8:0]  sym;
  logic        sym_vld;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic        m_last, m_err, m_valid, m_ready, in_frame, overflow;

  int          checks = 0;
  int          errors = 0;
  int          ovf_cnt = 0;
  logic [37:0] exp_q [$];
  logic [37:0] obs_q [$];

  frame_assembler #(
    .DEPTH     (4),
    .MAX_WORDS (256)
  ) dut (
    .byteclk  (byteclk),
    .rst_n    (rst_n),
    .link     (link),
    .sym      (sym),
    .sym_vld  (sym_vld),
    .m_data   (m_data),
    .m_keep   (m_keep),
    .m_last   (m_last),
    .m_err    (m_err),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .in_frame (in_frame),
    .overflow (overflow)
  );

  always #5 byteclk = ~byteclk;

  always @(negedge byteclk) begin
    if (rst_n && m_valid && m_ready) obs_q.push_back({m_data, m_keep, m_last, m_err});
    if (rst_n && overflow) ovf_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Hold inputs for one cycle; returns 1 time unit after the sampling edge.
  task automatic drive(input logic v, input logic [8:0] s, input logic l);
    sym_vld = v;
    sym     = s;
    link    = l;
    @(posedge byteclk);
    #1;
  endtask

  // Expected words for one frame from its payload bytes and whether it ended badly.
  function automatic void model_frame(input bq_t b, input bit bad);
    int          n = b.size();
    logic        err = bad;
    logic [31:0] d;
    logic [3:0]  k;
    logic        last;
    if (n == 0) begin
      exp_q.push_back({32'h0, 4'h0, 1'b1, 1'b1});
      return;
    end
`ifdef FRAME_XOR_CHECK_EN
    begin
      logic [7:0] x = 8'h00;
      foreach (b[i]) x ^= b[i];
      if (x != 8'h00) err = 1'b1;
    end
`endif
    for (int w = 0; w * 4 < n; w++) begin
      d = '0;
      k = '0;
      for (int j = 0; j < 4 && w * 4 + j < n; j++) begin
        d[8*j +: 8] = b[w*4+j];
        k[j]        = 1'b1;
      end
      last = (w * 4 + 4 >= n);
      exp_q.push_back({d, k, last, last ? err : 1'b0});
    end
  endfunction

  // term: 0 = EOF, 1 = link drop, 2 = SOF (restart)
  task automatic send_frame(input bq_t b, input int term, input bit skip_sof, input bit noisy);
    bit stray;
    int sp;
    stray = 1'b0;
    sp    = -1;
    if (noisy && b.size() > 0 && $urandom_range(0, 4) == 0) sp = $urandom_range(0, b.size() - 1);
    if (!skip_sof) drive(1'b1, SOF, 1'b1);
    foreach (b[i]) begin
      if (noisy && $urandom_range(0, 3) == 0) drive(1'b0, 9'h000, 1'b1);
      if (i == sp) begin
        drive(1'b1, KSTRAY, 1'b1);
        stray = 1'b1;
      end
      drive(1'b1, {1'b0, b[i]}, 1'b1);
    end
    case (term)
      0:       drive(1'b1, EOF, 1'b1);
      1:       drive(1'b0, 9'h000, 1'b0);
      default: drive(1'b1, SOF, 1'b1);
    endcase
    model_frame(b, stray || (term != 0));
    check("in_frame after terminator", in_frame, (term == 2));
  endtask

  task automatic check_drain(input string tag);
    int n;
    n = exp_q.size();
    for (int c = 0; c < 200 && obs_q.size() < n; c++) @(posedge byteclk);
    repeat (4) @(posedge byteclk);
    #1;
    check({tag, " word count"}, obs_q.size(), n);
    for (int i = 0; i < n && i < obs_q.size(); i++)
      check($sformatf("%s word %0d", tag, i), obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    bq_t b;
    int  prev_term;
    rst_n   = 1'b0;
    link    = 1'b0;
    sym     = 9'h000;
    sym_vld = 1'b0;
    m_ready = 1'b1;
    repeat (3) @(posedge byteclk);
    #1;
    check("reset m_valid", m_valid, 1'b0);
    check("reset m_data", m_data, 32'h0);
    check("reset m_keep", m_keep, 4'h0);
    check("reset m_last", m_last, 1'b0);
    check("reset m_err", m_err, 1'b0);
    check("reset in_frame", in_frame, 1'b0);
    check("reset overflow", overflow, 1'b0);
    rst_n = 1'b1;
    drive(1'b0, 9'h000, 1'b1);
    drive(1'b0, 9'h000, 1'b1);

    // Five-byte frame: one full word then a single-lane last word.
    b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    send_frame(b, 0, 1'b0, 1'b0);
    for (int c = 0; c < 50 && obs_q.size() < 2; c++) @(posedge byteclk);
    #1;
    check("five-byte word0", (obs_q.size() > 0) ? obs_q[0] : 38'h0, {32'h04030201, 4'hF, 1'b0, 1'b0});
    check("five-byte word1 data/keep/last", (obs_q.size() > 1) ? obs_q[1][37:1] : 37'h0,
          {32'h00000005, 4'h1, 1'b1});
    check_drain("five-byte");

    b = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
    send_frame(b, 0, 1'b0, 1'b0);
    check_drain("eight-byte");

    b = {};
    send_frame(b, 0, 1'b0, 1'b0);
    check_drain("empty");

    b = '{8'hA0, 8'hA1, 8'hA2};
    send_frame(b, 1, 1'b0, 1'b0);
    check_drain("link-drop");

    b = '{8'h11, 8'h22, 8'h33};
    send_frame(b, 0, 1'b0, 1'b0);
    b = '{8'h11, 8'h22, 8'h34};
    send_frame(b, 0, 1'b0, 1'b0);
    check_drain("checksum");

    // EOF to m_last on m_valid in one cycle.
    b = '{8'hA5};
    send_frame(b, 0, 1'b0, 1'b0);
    check("latency m_valid", m_valid, 1'b1);
    check("latency m_last", m_last, 1'b1);
    check_drain("latency");

    // Backpressure: three words fit, the fourth overflows, the terminator takes the last slot.
    m_ready = 1'b0;
    drive(1'b1, SOF, 1'b1);
    for (int i = 0; i < 20; i++) drive(1'b1, {1'b0, 8'(i + 1)}, 1'b1);
    drive(1'b1, EOF, 1'b1);
    drive(1'b0, 9'h000, 1'b1);
    for (int k = 0; k < 3; k++) begin
      check("stall m_valid", m_valid, 1'b1);
      check("stall m_data", m_data, 32'h04030201);
      drive(1'b0, 9'h000, 1'b1);
    end
    check("after overflow in_frame", in_frame, 1'b0);
    exp_q.push_back({32'h04030201, 4'hF, 1'b0, 1'b0});
    exp_q.push_back({32'h08070605, 4'hF, 1'b0, 1'b0});
    exp_q.push_back({32'h0C0B0A09, 4'hF, 1'b0, 1'b0});
    exp_q.push_back({32'h00000000, 4'h0, 1'b1, 1'b1});
    m_ready = 1'b1;
    check_drain("overflow");
    check("overflow pulse count", ovf_cnt, 1);

    // Randomized frames with idle noise, stray K symbols and all terminator kinds.
    prev_term = 0;
    for (int f = 0; f < 40; f++) begin
      int n;
      int term;
      logic [7:0] x;
      if (prev_term != 2) begin
        for (int g = $urandom_range(0, 3); g > 0; g--) begin
          case ($urandom_range(0, 2))
            0:       drive(1'b0, 9'h000, 1'b1);
            1:       drive(1'b1, {1'b0, 8'($urandom_range(0, 255))}, 1'b1);
            default: drive(1'b1, EOF, 1'b1);
          endcase
        end
      end
      n = $urandom_range(0, 12);
      b = {};
      x = 8'h00;
      for (int i = 0; i < n; i++) begin
        b.push_back(8'($urandom_range(0, 255)));
        if (i == n - 1 && $urandom_range(0, 1) == 1) b[i] = x;
        x ^= b[i];
      end
      term = (f == 39) ? 0 : ($urandom_range(0, 3) == 3 ? 2 : $urandom_range(0, 1));
      send_frame(b, term, prev_term == 2, 1'b1);
      prev_term = term;
    end
    check_drain("random");
    check("total overflow pulses", ovf_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
